// File: rtl/execution.sv
// execution -- execute stage of the vector ASIP.
//   Four independent IEEE-754 single-precision lanes sharing one alu_func:
//     alu_func = 1 : r_i = cte_i * pix_i
//     alu_func = 0 : r_i = mul_(2i-1) + mul_(2i)
//   Two-edge latency (operand register, result register), one result per cycle,
//   no handshake. Round-to-nearest-even. Subnormals in and out flush to signed
//   zero. Every NaN result is the canonical quiet NaN 32'h7FC0_0000.
//   Optional build macro EXE_SATURATE_EN: a finite overflow returns the signed
//   max finite value instead of a signed infinity. Infinite operands still give
//   infinity.
module execution (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_func,
  input  logic [31:0] cte1,
  input  logic [31:0] cte2,
  input  logic [31:0] cte3,
  input  logic [31:0] cte4,
  input  logic [31:0] pix1,
  input  logic [31:0] pix2,
  input  logic [31:0] pix3,
  input  logic [31:0] pix4,
  input  logic [31:0] mul1,
  input  logic [31:0] mul2,
  input  logic [31:0] mul3,
  input  logic [31:0] mul4,
  input  logic [31:0] mul5,
  input  logic [31:0] mul6,
  input  logic [31:0] mul7,
  input  logic [31:0] mul8,
  output logic [31:0] r1,
  output logic [31:0] r2,
  output logic [31:0] r3,
  output logic [31:0] r4
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Result returned when a finite computation exceeds the exponent range.
  function automatic logic [31:0] overflow_value(input logic s);
`ifdef EXE_SATURATE_EN
    return {s, 8'hFE, 23'h7F_FFFF};
`else
    return {s, 8'hFF, 23'h00_0000};
`endif
  endfunction

  // Round a normalised 24-bit significand (leading 1 at bit 23) to nearest-even,
  // then handle a carry out of rounding, overflow and underflow. st is the OR of
  // every bit below the guard bit.
  function automatic logic [31:0] round_pack(input logic              s,
                                             input logic signed [9:0] e_in,
                                             input logic [23:0]       m,
                                             input logic              g,
                                             input logic              st);
    logic [24:0]       m_r;
    logic [22:0]       frac;
    logic signed [9:0] e;
    logic [31:0]       res;
    m_r = {1'b0, m} + {24'd0, g & (st | m[0])};
    e   = e_in;
    if (m_r[24]) begin
      // 1.111..1 rounded up to 10.000..0: bump the exponent, fraction is zero.
      e    = e + 10'sd1;
      frac = m_r[23:1];
    end else begin
      frac = m_r[22:0];
    end
    if (e >= 10'sd255)    res = overflow_value(s);
    else if (e <= 10'sd0) res = {s, 31'd0};
    else                  res = {s, e[7:0], frac};
    return res;
  endfunction

  // Number of leading zeros in a non-zero 27-bit value.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  // FP32 multiply.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0]       prod;
    logic signed [9:0] e;
    logic [31:0]       res;
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    // Exponent field 0 covers both zero and subnormal: both behave as zero.
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e      = 10'(a[30:23]) + 10'(b[30:23]) - 10'sd127;
    if (a_nan || b_nan)                          res = QNAN;
    else if ((a_inf && b_zero) || (b_inf && a_zero)) res = QNAN;
    else if (a_inf || b_inf)                     res = {s, 8'hFF, 23'd0};
    else if (a_zero || b_zero)                   res = {s, 31'd0};
    else if (prod[47])                           // product in [2,4)
      res = round_pack(s, e + 10'sd1, prod[47:24], prod[23], |prod[22:0]);
    else                                         // product in [1,2)
      res = round_pack(s, e, prod[46:23], prod[22], |prod[21:0]);
    return res;
  endfunction

  // FP32 add. x is the operand of larger magnitude; y is aligned to it with
  // guard/round/sticky bits held in the low three bits of a 27-bit significand.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0]       x, y;
    logic [7:0]        d;
    logic [26:0]       mx, my, my_sh, mask, n;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] e;
    logic [31:0]       res;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d     = x[30:23] - y[30:23];
    mx    = {1'b1, x[22:0], 3'b000};
    my    = {1'b1, y[22:0], 3'b000};
    mask  = (27'd1 << d) - 27'd1;
    my_sh = (my >> d) | {26'd0, |(my & mask)};
    e     = 10'(x[30:23]);
    sum   = {1'b0, mx} + {1'b0, my_sh};
    n     = mx - my_sh;
    lz    = lzc27(n);
    if (a_nan || b_nan)                         res = QNAN;
    else if (a_inf && b_inf && (a[31] != b[31])) res = QNAN;
    else if (a_inf)                             res = a;
    else if (b_inf)                             res = b;
    else if (a_zero && b_zero)                  res = {a[31] & b[31], 31'd0};
    else if (a_zero)                            res = b;
    else if (b_zero)                            res = a;
    else if (d > 8'd25)                         res = x; // y is below half an ulp of x
    else if (x[31] == y[31]) begin
      if (sum[27]) res = round_pack(x[31], e + 10'sd1, sum[27:4], sum[3], |sum[2:0]);
      else         res = round_pack(x[31], e, sum[26:3], sum[2], |sum[1:0]);
    end else if (n == 27'd0) begin
      res = 32'h0000_0000;                         // exact cancellation is +0
    end else begin
      // Left shift is exact: a shift of 2+ implies d <= 1, so no sticky was lost.
      n   = n << lz;
      res = round_pack(x[31], e - 10'(lz), n[26:3], n[2], |n[1:0]);
    end
    return res;
  endfunction

  // Stage-1 operand registers.
  logic        r_func;
  logic [31:0] r_cte [4];
  logic [31:0] r_pix [4];
  logic [31:0] r_mul [8];
  // Stage-2 result registers.
  logic [31:0] r_res [4];
  logic [31:0] w_res [4];

  // Stage 1: capture the function select and all operand words every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand arrays are plain flops with reset, not a RAM, so that a
      // reset really discards work already in flight.
      r_func <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_cte[i] <= 32'd0;
        r_pix[i] <= 32'd0;
      end
      for (int i = 0; i < 8; i++) r_mul[i] <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_func   <= alu_func;
      r_cte[0] <= cte1;
      r_cte[1] <= cte2;
      r_cte[2] <= cte3;
      r_cte[3] <= cte4;
      r_pix[0] <= pix1;
      r_pix[1] <= pix2;
      r_pix[2] <= pix3;
      r_pix[3] <= pix4;
      r_mul[0] <= mul1;
      r_mul[1] <= mul2;
      r_mul[2] <= mul3;
      r_mul[3] <= mul4;
      r_mul[4] <= mul5;
      r_mul[5] <= mul6;
      r_mul[6] <= mul7;
      r_mul[7] <= mul8;
    end
  end

  // Per-lane arithmetic: only the selected operation is evaluated, so unknowns
  // on the unselected operands never reach the result.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      // NOTE: every path assigns w_res, so no latch is inferred.
      w_res[i] = 32'd0;
      if (r_func) w_res[i] = fp_mul(r_cte[i], r_pix[i]);
      else        w_res[i] = fp_add(r_mul[2*i], r_mul[2*i+1]);
    end
  end

  // Stage 2: register the lane results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_res[i] <= 32'd0;
    end else begin
      for (int i = 0; i < 4; i++) r_res[i] <= w_res[i];
    end
  end

  assign r1 = r_res[0];
  assign r2 = r_res[1];
  assign r3 = r_res[2];
  assign r4 = r_res[3];

endmodule

// File: tb/tb_execution.sv
// tb_execution -- directed-vector bench for the execution stage.
// Build with +define+EXE_SATURATE_EN to check the saturating overflow variant.
module tb_execution;

`ifdef EXE_SATURATE_EN
  localparam logic [31:0] OVF_P = 32'h7F7F_FFFF;
`else
  localparam logic [31:0] OVF_P = 32'h7F80_0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_func;
  logic [31:0] cte1, cte2, cte3, cte4;
  logic [31:0] pix1, pix2, pix3, pix4;
  logic [31:0] mul1, mul2, mul3, mul4, mul5, mul6, mul7, mul8;
  logic [31:0] r1, r2, r3, r4;

  int n_vec = 0;
  int n_bad = 0;

  // Operand words: multiply uses a[0..3]=cte, a[4..7]=pix; add uses a[0..7]=mul1..8.
  typedef struct packed {
    logic             func;
    logic [7:0][31:0] a;
    logic [3:0][31:0] e;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  execution dut (
    .clk(clk), .rst_n(rst_n), .alu_func(alu_func),
    .cte1(cte1), .cte2(cte2), .cte3(cte3), .cte4(cte4),
    .pix1(pix1), .pix2(pix2), .pix3(pix3), .pix4(pix4),
    .mul1(mul1), .mul2(mul2), .mul3(mul3), .mul4(mul4),
    .mul5(mul5), .mul6(mul6), .mul7(mul7), .mul8(mul8),
    .r1(r1), .r2(r2), .r3(r3), .r4(r4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_lanes(input string tag, input logic [3:0][31:0] e);
    check({tag, "_r1"}, r1, e[0]);
    check({tag, "_r2"}, r2, e[1]);
    check({tag, "_r3"}, r3, e[2]);
    check({tag, "_r4"}, r4, e[3]);
  endtask

  task automatic set_mul(input int idx,
                         input logic [31:0] c1, c2, c3, c4, p1, p2, p3, p4,
                         input logic [31:0] e1, e2, e3, e4);
    vecs[idx].func = 1'b1;
    vecs[idx].a[0] = c1; vecs[idx].a[1] = c2; vecs[idx].a[2] = c3; vecs[idx].a[3] = c4;
    vecs[idx].a[4] = p1; vecs[idx].a[5] = p2; vecs[idx].a[6] = p3; vecs[idx].a[7] = p4;
    vecs[idx].e[0] = e1; vecs[idx].e[1] = e2; vecs[idx].e[2] = e3; vecs[idx].e[3] = e4;
  endtask

  task automatic set_add(input int idx,
                         input logic [31:0] m1, m2, m3, m4, m5, m6, m7, m8,
                         input logic [31:0] e1, e2, e3, e4);
    vecs[idx].func = 1'b0;
    vecs[idx].a[0] = m1; vecs[idx].a[1] = m2; vecs[idx].a[2] = m3; vecs[idx].a[3] = m4;
    vecs[idx].a[4] = m5; vecs[idx].a[5] = m6; vecs[idx].a[6] = m7; vecs[idx].a[7] = m8;
    vecs[idx].e[0] = e1; vecs[idx].e[1] = e2; vecs[idx].e[2] = e3; vecs[idx].e[3] = e4;
  endtask

  // Unselected operands are driven to X to show they cannot leak into results.
  task automatic drive(input vec_t v);
    alu_func = v.func;
    if (v.func) begin
      cte1 = v.a[0]; cte2 = v.a[1]; cte3 = v.a[2]; cte4 = v.a[3];
      pix1 = v.a[4]; pix2 = v.a[5]; pix3 = v.a[6]; pix4 = v.a[7];
      mul1 = 'x; mul2 = 'x; mul3 = 'x; mul4 = 'x;
      mul5 = 'x; mul6 = 'x; mul7 = 'x; mul8 = 'x;
    end else begin
      mul1 = v.a[0]; mul2 = v.a[1]; mul3 = v.a[2]; mul4 = v.a[3];
      mul5 = v.a[4]; mul6 = v.a[5]; mul7 = v.a[6]; mul8 = v.a[7];
      cte1 = 'x; cte2 = 'x; cte3 = 'x; cte4 = 'x;
      pix1 = 'x; pix2 = 'x; pix3 = 'x; pix4 = 'x;
    end
  endtask

  task automatic drive_zero();
    alu_func = 1'b0;
    cte1 = '0; cte2 = '0; cte3 = '0; cte4 = '0;
    pix1 = '0; pix2 = '0; pix3 = '0; pix4 = '0;
    mul1 = '0; mul2 = '0; mul3 = '0; mul4 = '0;
    mul5 = '0; mul6 = '0; mul7 = '0; mul8 = '0;
  endtask

  task automatic drive_random();
    alu_func = 1'b1;
    cte1 = $urandom(); cte2 = $urandom(); cte3 = $urandom(); cte4 = $urandom();
    pix1 = $urandom(); pix2 = $urandom(); pix3 = $urandom(); pix4 = $urandom();
    mul1 = $urandom(); mul2 = $urandom(); mul3 = $urandom(); mul4 = $urandom();
    mul5 = $urandom(); mul6 = $urandom(); mul7 = $urandom(); mul8 = $urandom();
  endtask

  initial begin
    // 2.0 * 3.0 = 6.0 on every lane
    set_mul(0, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000,
               32'h4040_0000, 32'h4040_0000, 32'h4040_0000, 32'h4040_0000,
               32'h40C0_0000, 32'h40C0_0000, 32'h40C0_0000, 32'h40C0_0000);
    // 1.5 + 2.5 = 4.0 on every lane
    set_add(1, 32'h3FC0_0000, 32'h4020_0000, 32'h3FC0_0000, 32'h4020_0000,
               32'h3FC0_0000, 32'h4020_0000, 32'h3FC0_0000, 32'h4020_0000,
               32'h4080_0000, 32'h4080_0000, 32'h4080_0000, 32'h4080_0000);
    // 3*10, -1*20, 0*30, 0.5*40
    set_mul(2, 32'h4040_0000, 32'hBF80_0000, 32'h0000_0000, 32'h3F00_0000,
               32'h4120_0000, 32'h41A0_0000, 32'h41F0_0000, 32'h4220_0000,
               32'h41F0_0000, 32'hC1A0_0000, 32'h0000_0000, 32'h41A0_0000);
    // inf+-inf, 1+-1, NaN+1, max+max
    set_add(3, 32'h7F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'hBF80_0000,
               32'h7F80_0001, 32'h3F80_0000, 32'h7F7F_FFFF, 32'h7F7F_FFFF,
               32'h7FC0_0000, 32'h0000_0000, 32'h7FC0_0000, OVF_P);
    // 2^127*8 overflow, inf*0, -inf*2, -0*5
    set_mul(4, 32'h7F00_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h8000_0000,
               32'h4100_0000, 32'h0000_0000, 32'h4000_0000, 32'h40A0_0000,
               OVF_P, 32'h7FC0_0000, 32'hFF80_0000, 32'h8000_0000);
    // 1+2^-30 (d>25), subnormal + -0, 1+2^-24 (tie to even), 1+1.5*2^-23 (tie up)
    set_add(5, 32'h3F80_0000, 32'h3080_0000, 32'h0040_0000, 32'h8000_0000,
               32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 32'h3440_0000,
               32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0002);
    // underflow, negative underflow, (1+2^-23)^2 rounds down, NaN*1
    set_mul(6, 32'h0D80_0000, 32'h8D80_0000, 32'h3F80_0001, 32'hFFFF_FFFF,
               32'h0D80_0000, 32'h0D80_0000, 32'h3F80_0001, 32'h3F80_0000,
               32'h0000_0000, 32'h8000_0000, 32'h3F80_0002, 32'h7FC0_0000);
    // 1-0.75, -2.5+1, subnormal difference flushes to -0, -0 + -0
    set_add(7, 32'h3F80_0000, 32'hBF40_0000, 32'hC020_0000, 32'h3F80_0000,
               32'h0080_0000, 32'h80C0_0000, 32'h8000_0000, 32'h8000_0000,
               32'h3E80_0000, 32'hBFC0_0000, 32'h8000_0000, 32'h8000_0000);

    // Reset asserted mid-cycle with live inputs clears the outputs at once.
    rst_n = 1'b1;
    drive_random();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_lanes("rst_async", 32'd0);
    repeat (2) @(posedge clk);
    drive_zero();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 check_lanes("rst_edge1", 32'd0);
    @(posedge clk); #1 check_lanes("rst_edge2", 32'd0);

    // Back-to-back stream alternating multiply/add: the result of vector k-1 is
    // visible right after the edge that samples vector k.
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) drive(vecs[k]);
      else       drive_zero();
      @(posedge clk); #1;
      if (k > 0) check_lanes($sformatf("vec%0d", k - 1), vecs[k - 1].e);
    end

    // Reset while a vector sits in stage 1: it must never appear.
    drive(vecs[0]);
    @(posedge clk); #1;
    drive(vecs[1]);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1 check_lanes("midrst_async", 32'd0);
    #1 rst_n = 1'b1;
    drive_zero();
    @(posedge clk); #1 check_lanes("midrst_edge1", 32'd0);
    @(posedge clk); #1 check_lanes("midrst_edge2", 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
